updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter with programmable modulus, wrap or saturate mode, synchronous load, built-in tick prescaler and terminal-count and overflow flags. It replaces the fixed-width free-running up/down/hold/clear counter used in the sequential-counter set. It keeps the same 2-bit command encoding so existing control logic drives it unchanged. It sits behind timer, PWM-period and event-count logic that needs a bounded count range and boundary indication.

## Interface
- N, 8: counter width in bits (N ≥ 2).
- L, 4: width of the `q_msb` slice output (1 ≤ L ≤ N).
- PRE, 1: prescale ratio; a count step is allowed every PRE enabled cycles (PRE ≥ 1).

- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; gates the prescaler and counting.
- s  in  2  command: 0 up, 1 down, 2 hold, 3 clear.
- mode  in  1  0 wrap, 1 saturate.
- max  in  N  upper count limit (modulus − 1), sampled every cycle.
- load  in  1  synchronous load of `d`.
- d  in  N  load value.
- q  out  N  registered count.
- q_msb  out  L  `q[N-1:N-L]`, combinational slice of `q`.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf  out  1  sticky boundary flag.

## Operation
- Per-edge priority: RST > clear (s=3) > load > step > hold.
- **Clear (s=3)**
  - q←0, ovf←0, tc←0, prescaler←0.
  - Independent of `en`, tick and `load`.
- **Load (load=1, s≠3)**
  - q←min(d, max).
  - Prescaler←0, tc←0.
  - ovf is unchanged.
  - Independent of `en`.
- **Step**
  - Occurs only when en=1, the prescaler tick=1, and s∈{0,1}.
- **Up step**
  - If q < max: q←q+1.
  - Else (q ≥ max, boundary):
    - wrap: q←0.
    - saturate: q←max.
- **Down step**
  - If q ≠ 0 and q ≤ max: q←q−1.
  - If q = 0 (boundary):
    - wrap: q←max.
    - saturate: q stays 0.
  - If q > max (possible after `max` is lowered): q←max, and the step is not a boundary.
- **Boundary step**
  - tc←1 for the following cycle.
  - ovf←1 and stays set until clear or RST.
  - The flags fire in both modes, including repeated saturation attempts.
- **Hold**
  - s=2, or en=0, or no tick: q is unchanged and tc←0.
- **Arithmetic**
  - Unsigned, N bits.
  - Next-state is computed as N+1 bits internally; there is no silent modulo-2^N wrap.
  - max=0: up and down steps are both boundary steps, and q stays 0.
- **Prescaler**
  - Modulo-PRE counter that advances only when en=1.
  - tick=1 when its count = PRE−1, then the counter returns to 0.
  - PRE=1: tick is constant 1.
  - s=2 (hold) does not stop the prescaler.

## Timing
- RST asserted: immediately q=0, tc=0, ovf=0, prescaler=0.
- Release of RST is synchronous to CLK by the surrounding design.
- RST asserted mid-operation aborts any step; there is no partial update.
- Latency:
  - Command, load and step take effect on the first rising edge after they are sampled.
  - `tc` is high for exactly one cycle after the boundary edge.
- With PRE=P and en held at 1: one step every P cycles; the first step occurs P edges after reset, clear or load.
- Changing `max` takes effect on the next edge. It does not itself modify q; only the next step or load applies the new limit.
- Simultaneous load and clear: clear wins.
- Simultaneous load and step: load wins and the step is discarded.

## Structure
- Shared package `counter_pkg`:
  - Command constants CMD_UP=0, CMD_DOWN=1, CMD_HOLD=2, CMD_CLR=3.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
- Sub-module `tick_prescaler`:
  - Parameter PRE; ports CLK, RST, en, clr, tick.
  - `clr` is driven by clear or load.
- Top level holds the q, tc and ovf registers and the next-state logic as a combinational block plus a clocked block.

## Test plan
- **Wrap up:** N=8, PRE=1, max=9, mode=0, s=0, en=1 for 12 cycles after reset → q 1…9, 0, 1, 2; tc high one cycle after the 9→0 edge; ovf=1 afterwards.
- **Saturate down:** load d=2, mode=1, s=1 for 4 steps → q 1, 0, 0, 0; tc pulses on each of the last two steps; ovf=1. Then s=3 → q=0, ovf=0.
- **Load clamp:** max=20, load d=200 → q=20. Then max=5 and one down step → q=5 with no tc.
- **Prescaler:** PRE=3, s=0, en=1 → q increments on cycles 3, 6, 9. Drop en for 2 cycles → q and phase frozen, then resume.
- **Priority:** load=1 with s=3 → q=0. load=1, d=7 with an up tick → q=7. s=2 → q stable for 10 cycles.
- **Async reset:** assert RST between edges at q=6 → q, tc, ovf are 0 before the next edge, and q_msb=0.

Source files
------------

// File: rtl/updown_mod_counter_pkg.sv
// counter_pkg: command and mode encodings shared by the counter and its control logic
package counter_pkg;
  localparam logic [1:0] CMD_UP   = 2'd0;
  localparam logic [1:0] CMD_DOWN = 2'd1;
  localparam logic [1:0] CMD_HOLD = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control inputs and count/flag outputs of the modulus counter
interface updown_mod_counter_if #(parameter int N = 8, parameter int L = 4);
  logic         en;
  logic [1:0]   s;
  logic         mode;
  logic [N-1:0] max;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic [L-1:0] q_msb;
  logic         tc;
  logic         ovf;
  modport master(output en, s, mode, max, load, d, input q, q_msb, tc, ovf);
  modport slave(input en, s, mode, max, load, d, output q, q_msb, tc, ovf);
endinterface

// File: rtl/updown_mod_counter_tick_prescaler.sv
// tick_prescaler: modulo-PRE phase counter that advances on enabled cycles only
module tick_prescaler #(parameter int PRE = 1) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = PRE > 1 ? $clog2(PRE) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  // tick on the last phase; clr restarts so the next step lands PRE enabled edges later
  always_comb begin
    tick = cnt_q == W'(PRE - 1);
    cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + W'(1);
  end
  // phase register
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter with programmable limit, wrap/saturate, load and flags
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N   = 8,
  parameter int L   = 4,
  parameter int PRE = 1
) (
  input logic CLK,
  input logic RST,
  updown_mod_counter_if.slave bus
);
  logic [N-1:0] q_q, q_d, ld_val, step_val;
  logic [N:0]   inc;
  logic         tc_q, tc_d, ovf_q, ovf_d;
  logic         tick, clr, step, up, sat, up_bnd, dn_bnd, bnd;
  tick_prescaler #(.PRE(PRE)) u_pre (
    .CLK(CLK), .RST(RST), .en(bus.en), .clr(clr | bus.load), .tick(tick)
  );
  // next count and flags; clear beats load beats step, and the increment keeps its carry
  always_comb begin
    clr = bus.s == CMD_CLR;
    up = bus.s == CMD_UP;
    sat = bus.mode == MODE_SAT;
    step = bus.en & tick & ~bus.s[1];
    inc = {1'b0, q_q} + (N+1)'(1);
    up_bnd = inc > {1'b0, bus.max};
    dn_bnd = q_q == '0;
    bnd = step & (up ? up_bnd : dn_bnd);
    ld_val = bus.d > bus.max ? bus.max : bus.d;
    step_val = up ? (up_bnd ? (sat ? bus.max : '0) : inc[N-1:0])
             : dn_bnd ? (sat ? '0 : bus.max)
             : q_q > bus.max ? bus.max : q_q - N'(1);
    q_d = clr ? '0 : bus.load ? ld_val : step ? step_val : q_q;
    tc_d = ~clr & ~bus.load & bnd;
    ovf_d = ~clr & (ovf_q | (~bus.load & bnd));
  end
  // count and flag registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      q_q <= '0;
      tc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q <= q_d;
      tc_q <= tc_d;
      ovf_q <= ovf_d;
    end
  assign bus.q = q_q;
  assign bus.q_msb = q_q[N-1:N-L];
  assign bus.tc = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of wrap, saturate, clamp, prescaler, priority and async reset
module tb_updown_mod_counter;
  import counter_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int ntot = 0;
  int npass = 0;
  updown_mod_counter_if #(.N(8), .L(4)) a ();
  updown_mod_counter_if #(.N(8), .L(4)) b ();
  updown_mod_counter #(.N(8), .L(4), .PRE(1)) dut_a (.CLK(CLK), .RST(RST), .bus(a));
  updown_mod_counter #(.N(8), .L(4), .PRE(3)) dut_b (.CLK(CLK), .RST(RST), .bus(b));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic tk();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    a.en = 0; a.s = CMD_HOLD; a.mode = MODE_WRAP; a.max = 8'd9; a.load = 0; a.d = 0;
    b.en = 0; b.s = CMD_HOLD; b.mode = MODE_WRAP; b.max = 8'd50; b.load = 0; b.d = 0;
    #2;
    chk("reset_q", 32'(a.q), 0);
    chk("reset_tc", 32'(a.tc), 0);
    chk("reset_ovf", 32'(a.ovf), 0);
    tk();
    RST = 0;
    a.en = 1; a.s = CMD_UP;
    for (int i = 1; i <= 12; i++) begin
      tk();
      chk($sformatf("wrap_q_%0d", i), 32'(a.q), 32'(i % 10));
      chk($sformatf("wrap_tc_%0d", i), 32'(a.tc), 32'(i == 10));
      chk($sformatf("wrap_ovf_%0d", i), 32'(a.ovf), 32'(i >= 10));
    end
    a.load = 1; a.d = 8'd2; a.mode = MODE_SAT; a.s = CMD_DOWN;
    tk();
    chk("sat_load_q", 32'(a.q), 2);
    chk("sat_load_ovf_kept", 32'(a.ovf), 1);
    chk("sat_load_tc", 32'(a.tc), 0);
    a.load = 0;
    tk(); chk("sat_q1", 32'(a.q), 1); chk("sat_tc1", 32'(a.tc), 0);
    tk(); chk("sat_q2", 32'(a.q), 0); chk("sat_tc2", 32'(a.tc), 0);
    tk(); chk("sat_q3", 32'(a.q), 0); chk("sat_tc3", 32'(a.tc), 1);
    tk(); chk("sat_q4", 32'(a.q), 0); chk("sat_tc4", 32'(a.tc), 1);
    chk("sat_ovf", 32'(a.ovf), 1);
    a.s = CMD_CLR;
    tk();
    chk("clr_q", 32'(a.q), 0);
    chk("clr_ovf", 32'(a.ovf), 0);
    chk("clr_tc", 32'(a.tc), 0);
    a.s = CMD_HOLD; a.max = 8'd20; a.load = 1; a.d = 8'd200;
    tk();
    chk("clamp_q", 32'(a.q), 20);
    chk("clamp_q_msb", 32'(a.q_msb), 1);
    a.load = 0; a.max = 8'd5;
    tk();
    chk("max_low_hold_q", 32'(a.q), 20);
    a.s = CMD_DOWN;
    tk();
    chk("max_low_down_q", 32'(a.q), 5);
    chk("max_low_down_tc", 32'(a.tc), 0);
    chk("max_low_down_ovf", 32'(a.ovf), 0);
    a.load = 1; a.d = 8'd3; a.s = CMD_CLR;
    tk();
    chk("prio_clr_over_load", 32'(a.q), 0);
    a.max = 8'd20; a.d = 8'd7; a.s = CMD_UP;
    tk();
    chk("prio_load_over_step", 32'(a.q), 7);
    a.load = 0; a.s = CMD_HOLD;
    for (int i = 0; i < 10; i++) begin
      tk();
      chk($sformatf("hold_q_%0d", i), 32'(a.q), 7);
    end
    chk("hold_tc", 32'(a.tc), 0);
    a.max = 8'd0; a.s = CMD_UP;
    tk();
    chk("max0_up_q", 32'(a.q), 0);
    chk("max0_up_tc", 32'(a.tc), 1);
    chk("max0_up_ovf", 32'(a.ovf), 1);
    a.s = CMD_DOWN;
    tk();
    chk("max0_dn_q", 32'(a.q), 0);
    chk("max0_dn_tc", 32'(a.tc), 1);
    a.max = 8'd20; a.load = 1; a.d = 8'd6; a.s = CMD_HOLD;
    tk();
    chk("pre_rst_q", 32'(a.q), 6);
    chk("pre_rst_ovf", 32'(a.ovf), 1);
    a.load = 0;
    #2 RST = 1;
    #1;
    chk("arst_q", 32'(a.q), 0);
    chk("arst_tc", 32'(a.tc), 0);
    chk("arst_ovf", 32'(a.ovf), 0);
    chk("arst_q_msb", 32'(a.q_msb), 0);
    tk();
    RST = 0;
    b.en = 1; b.s = CMD_UP;
    for (int i = 1; i <= 10; i++) begin
      tk();
      chk($sformatf("pre_q_%0d", i), 32'(b.q), 32'(i / 3));
    end
    b.en = 0;
    tk(); chk("pre_frz_q1", 32'(b.q), 3);
    tk(); chk("pre_frz_q2", 32'(b.q), 3);
    b.en = 1;
    tk(); chk("pre_res_q1", 32'(b.q), 3);
    tk(); chk("pre_res_q2", 32'(b.q), 4);
    b.load = 1; b.d = 8'd10;
    tk(); chk("pre_load_q", 32'(b.q), 10);
    b.load = 0;
    tk(); chk("pre_ld_q1", 32'(b.q), 10);
    tk(); chk("pre_ld_q2", 32'(b.q), 10);
    tk(); chk("pre_ld_q3", 32'(b.q), 11);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
